// File: rtl/data_structures.sv
// Shared core types: ALU opcodes and the NZCV flag bundle, plus default
// datapath widths for blocks that size themselves from GPR_SIZE / ROB_IDX_SIZE.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package data_structures;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORR = 4'd3,
        ALU_EOR = 4'd4,
        ALU_MOV = 4'd5
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;
endpackage

// File: rtl/rs_pkg.sv
// Reservation station types: source operand slot, entry record, ROB age helper.
// Field widths follow GPR_SIZE / ROB_IDX_SIZE.
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package rs_pkg;
    import data_structures::*;

    localparam int RS_DATA_W = `GPR_SIZE;
    localparam int RS_ROB_W  = `ROB_IDX_SIZE;

    // All-ones pattern; slice down to the entry index width where used.
    localparam logic [31:0] RS_IDX_INVALID = '1;

    typedef struct packed {
        logic                 valid;
        logic [RS_DATA_W-1:0] value;
        logic [RS_ROB_W-1:0]  rob_index;
    } rs_src_t;

    typedef struct packed {
        logic                valid;
        alu_op_t             op;
        rs_src_t [1:0]       src;
        logic                uses_nzcv;
        logic                nzcv_valid;
        nzcv_t               nzcv;
        logic [RS_ROB_W-1:0] nzcv_rob_index;
        logic                set_nzcv;
        logic [RS_ROB_W-1:0] dst_rob_index;
    } rs_entry_param_t;

    // Distance from the ROB head; wraps naturally with the tag width.
    function automatic logic [RS_ROB_W-1:0] rob_age(input logic [RS_ROB_W-1:0] idx,
                                                    input logic [RS_ROB_W-1:0] head);
        return idx - head;
    endfunction
endpackage

// File: rtl/rs_select.sv
// Issue picker: ready bitmap + per-entry ROB ages -> {found, index}.
// RS_OLDEST_FIRST_EN selects the smallest age; otherwise the lowest index wins
// and the ages are ignored.
module rs_select
    import rs_pkg::*;
#(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = $clog2(RS_SIZE),
    parameter int AGE_W    = 4
) (
    input  logic [RS_SIZE-1:0]            in_ready,
    input  logic [RS_SIZE-1:0][AGE_W-1:0] in_age,
    output logic                          out_found,
    output logic [RS_IDX_W-1:0]           out_index
);
`ifdef RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0] best_age;

    // Linear min-search over ready entries; ROB tags are unique so ages never tie.
    always_comb begin
        out_found = 1'b0;
        out_index = RS_IDX_INVALID[RS_IDX_W-1:0];
        best_age  = '1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (in_ready[i] && (!out_found || (in_age[i] < best_age))) begin
                out_found = 1'b1;
                out_index = i[RS_IDX_W-1:0];
                best_age  = in_age[i];
            end
        end
    end
`else
    logic unused_age;
    assign unused_age = ^in_age;

    // Priority encoder: walk high to low so the lowest ready index is the last writer.
    always_comb begin
        out_found = 1'b0;
        out_index = RS_IDX_INVALID[RS_IDX_W-1:0];
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (in_ready[i]) begin
                out_found = 1'b1;
                out_index = i[RS_IDX_W-1:0];
            end
        end
    end
`endif
endmodule

// File: rtl/reservation_station_param.sv
// Reservation station between ROB dispatch and one functional unit.
// Captures operands/NZCV from NUM_BCAST wakeup ports, issues one ready entry per
// cycle, squashes entries younger than a mispredicted branch on flush.
// Optional macro RS_OLDEST_FIRST_EN: oldest-ready issue instead of lowest-index.
// DATA_W / ROB_IDX_W must match GPR_SIZE / ROB_IDX_SIZE (entry layout lives in rs_pkg).
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

module reservation_station_param
    import data_structures::*;
    import rs_pkg::*;
#(
    parameter int RS_SIZE   = 8,
    parameter int RS_IDX_W  = $clog2(RS_SIZE),
    parameter int DATA_W    = `GPR_SIZE,
    parameter int ROB_IDX_W = `ROB_IDX_SIZE,
    parameter int NUM_BCAST = 2
) (
    input  logic                                in_clk,
    input  logic                                in_rst_n,
    input  logic                                in_disp_valid,
    output logic                                out_disp_ready,
    input  alu_op_t                             in_disp_op,
    input  logic [1:0]                          in_disp_src_valid,
    input  logic [1:0][DATA_W-1:0]              in_disp_src_value,
    input  logic [1:0][ROB_IDX_W-1:0]           in_disp_src_rob_index,
    input  logic                                in_disp_uses_nzcv,
    input  logic                                in_disp_nzcv_valid,
    input  nzcv_t                               in_disp_nzcv,
    input  logic [ROB_IDX_W-1:0]                in_disp_nzcv_rob_index,
    input  logic                                in_disp_set_nzcv,
    input  logic [ROB_IDX_W-1:0]                in_disp_dst_rob_index,
    input  logic [NUM_BCAST-1:0]                in_bcast_valid,
    input  logic [NUM_BCAST-1:0][ROB_IDX_W-1:0] in_bcast_rob_index,
    input  logic [NUM_BCAST-1:0][DATA_W-1:0]    in_bcast_value,
    input  logic [NUM_BCAST-1:0]                in_bcast_set_nzcv,
    input  nzcv_t [NUM_BCAST-1:0]               in_bcast_nzcv,
    input  logic                                in_flush,
    input  logic [ROB_IDX_W-1:0]                in_flush_rob_index,
    input  logic [ROB_IDX_W-1:0]                in_rob_head_index,
    input  logic                                in_fu_ready,
    output logic                                out_issue_valid,
    output alu_op_t                             out_issue_op,
    output logic [DATA_W-1:0]                   out_issue_val_a,
    output logic [DATA_W-1:0]                   out_issue_val_b,
    output nzcv_t                               out_issue_nzcv,
    output logic                                out_issue_set_nzcv,
    output logic                                out_issue_uses_nzcv,
    output logic [ROB_IDX_W-1:0]                out_issue_dst_rob_index,
    output logic [RS_IDX_W:0]                   out_count
);
    rs_entry_param_t [RS_SIZE-1:0]            entries_q, entries_d;
    rs_entry_param_t                          new_entry;
    logic [RS_SIZE-1:0]                       ready;
    logic [RS_SIZE-1:0][ROB_IDX_W-1:0]        age;
    logic [ROB_IDX_W-1:0]                     flush_age;
    logic [RS_IDX_W-1:0]                      free_idx, sel_idx;
    logic [RS_IDX_W:0]                        count;
    logic                                     sel_found, disp_fire, issue_fire;

    // Capture any broadcast whose tag matches a still-pending operand or NZCV.
    // Ports are walked high to low so the lowest matching port is the last writer.
    function automatic rs_entry_param_t apply_bcast(
        input rs_entry_param_t                     e,
        input logic [NUM_BCAST-1:0]                bv,
        input logic [NUM_BCAST-1:0][ROB_IDX_W-1:0] btag,
        input logic [NUM_BCAST-1:0][DATA_W-1:0]    bval,
        input logic [NUM_BCAST-1:0]                bset,
        input nzcv_t [NUM_BCAST-1:0]               bnzcv);
        rs_entry_param_t r;
        r = e;
        for (int k = NUM_BCAST - 1; k >= 0; k--) begin
            for (int j = 0; j < 2; j++) begin
                if (!e.src[j].valid && bv[k] && (btag[k] == e.src[j].rob_index)) begin
                    r.src[j].valid = 1'b1;
                    r.src[j].value = bval[k];
                end
            end
            if (!e.nzcv_valid && bv[k] && bset[k] && (btag[k] == e.nzcv_rob_index)) begin
                r.nzcv_valid = 1'b1;
                r.nzcv       = bnzcv[k];
            end
        end
        return r;
    endfunction

    // Per-entry readiness, ROB age, occupancy count and lowest free slot.
    always_comb begin
        count    = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = entries_q[i].valid && entries_q[i].src[0].valid && entries_q[i].src[1].valid
                       && (!entries_q[i].uses_nzcv || entries_q[i].nzcv_valid);
            age[i]   = rob_age(entries_q[i].dst_rob_index, in_rob_head_index);
            count    = count + (RS_IDX_W+1)'(entries_q[i].valid);
            if (!entries_q[i].valid) free_idx = i[RS_IDX_W-1:0];
        end
        flush_age = rob_age(in_flush_rob_index, in_rob_head_index);
    end

    rs_select #(
        .RS_SIZE  (RS_SIZE),
        .RS_IDX_W (RS_IDX_W),
        .AGE_W    (ROB_IDX_W)
    ) u_select (
        .in_ready  (ready),
        .in_age    (age),
        .out_found (sel_found),
        .out_index (sel_idx)
    );

    // Handshakes; a flush cycle neither accepts nor issues.
    always_comb begin
        out_count       = count;
        out_disp_ready  = in_rst_n && (count != (RS_IDX_W+1)'(RS_SIZE)) && !in_flush;
        out_issue_valid = in_rst_n && sel_found && !in_flush;
        disp_fire       = in_disp_valid && out_disp_ready;
        issue_fire      = out_issue_valid && in_fu_ready;
    end

    // Issue payload straight from the selected entry.
    always_comb begin
        out_issue_op            = entries_q[sel_idx].op;
        out_issue_val_a         = entries_q[sel_idx].src[0].value;
        out_issue_val_b         = entries_q[sel_idx].src[1].value;
        out_issue_nzcv          = entries_q[sel_idx].nzcv;
        out_issue_set_nzcv      = entries_q[sel_idx].set_nzcv;
        out_issue_uses_nzcv     = entries_q[sel_idx].uses_nzcv;
        out_issue_dst_rob_index = entries_q[sel_idx].dst_rob_index;
    end

    // Incoming entry, including broadcasts that land in the dispatch cycle.
    always_comb begin
        new_entry                = '0;
        new_entry.valid          = 1'b1;
        new_entry.op             = in_disp_op;
        for (int j = 0; j < 2; j++) begin
            new_entry.src[j].valid     = in_disp_src_valid[j];
            new_entry.src[j].value     = in_disp_src_value[j];
            new_entry.src[j].rob_index = in_disp_src_rob_index[j];
        end
        new_entry.uses_nzcv      = in_disp_uses_nzcv;
        new_entry.nzcv_valid     = in_disp_nzcv_valid;
        new_entry.nzcv           = in_disp_nzcv;
        new_entry.nzcv_rob_index = in_disp_nzcv_rob_index;
        new_entry.set_nzcv       = in_disp_set_nzcv;
        new_entry.dst_rob_index  = in_disp_dst_rob_index;
        new_entry = apply_bcast(new_entry, in_bcast_valid, in_bcast_rob_index,
                                in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv);
    end

    // Next state: wakeup, issue retire, flush squash, then dispatch write.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = apply_bcast(entries_q[i], in_bcast_valid, in_bcast_rob_index,
                                       in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv);
        end
        if (issue_fire) entries_d[sel_idx].valid = 1'b0;
        if (in_flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (age[i] > flush_age) entries_d[i].valid = 1'b0;
            end
        end
        if (disp_fire) entries_d[free_idx] = new_entry;
    end

    // Entry storage with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) entries_q <= '0;
        else           entries_q <= entries_d;
    end
endmodule

// File: tb/tb_reservation_station_param.sv
// Directed bench for reservation_station_param: reset, dispatch/issue, wakeup,
// full/backpressure, flush with ROB wrap, select policy, dispatch-cycle capture.
module tb_reservation_station_param;
    import data_structures::*;

    localparam int RS_SIZE = 8;
    localparam int RS_IDX_W = 3;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int NB = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   disp_valid, disp_ready;
    alu_op_t                disp_op;
    logic [1:0]             disp_src_valid;
    logic [1:0][DW-1:0]     disp_src_value;
    logic [1:0][RW-1:0]     disp_src_rob;
    logic                   disp_uses_nzcv, disp_nzcv_valid, disp_set_nzcv;
    nzcv_t                  disp_nzcv;
    logic [RW-1:0]          disp_nzcv_rob, disp_dst_rob;
    logic [NB-1:0]          bc_valid, bc_set_nzcv;
    logic [NB-1:0][RW-1:0]  bc_rob;
    logic [NB-1:0][DW-1:0]  bc_value;
    nzcv_t [NB-1:0]         bc_nzcv;
    logic                   flush, fu_ready;
    logic [RW-1:0]          flush_rob, head;
    logic                   iss_valid, iss_set_nzcv, iss_uses_nzcv;
    alu_op_t                iss_op;
    logic [DW-1:0]          iss_a, iss_b;
    nzcv_t                  iss_nzcv;
    logic [RW-1:0]          iss_dst;
    logic [RS_IDX_W:0]      count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reservation_station_param dut (
        .in_clk(clk), .in_rst_n(rst_n),
        .in_disp_valid(disp_valid), .out_disp_ready(disp_ready), .in_disp_op(disp_op),
        .in_disp_src_valid(disp_src_valid), .in_disp_src_value(disp_src_value),
        .in_disp_src_rob_index(disp_src_rob), .in_disp_uses_nzcv(disp_uses_nzcv),
        .in_disp_nzcv_valid(disp_nzcv_valid), .in_disp_nzcv(disp_nzcv),
        .in_disp_nzcv_rob_index(disp_nzcv_rob), .in_disp_set_nzcv(disp_set_nzcv),
        .in_disp_dst_rob_index(disp_dst_rob),
        .in_bcast_valid(bc_valid), .in_bcast_rob_index(bc_rob), .in_bcast_value(bc_value),
        .in_bcast_set_nzcv(bc_set_nzcv), .in_bcast_nzcv(bc_nzcv),
        .in_flush(flush), .in_flush_rob_index(flush_rob), .in_rob_head_index(head),
        .in_fu_ready(fu_ready),
        .out_issue_valid(iss_valid), .out_issue_op(iss_op), .out_issue_val_a(iss_a),
        .out_issue_val_b(iss_b), .out_issue_nzcv(iss_nzcv), .out_issue_set_nzcv(iss_set_nzcv),
        .out_issue_uses_nzcv(iss_uses_nzcv), .out_issue_dst_rob_index(iss_dst),
        .out_count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_disp();
        disp_valid = 1'b0; disp_op = ALU_ADD; disp_src_valid = '0; disp_src_value = '0;
        disp_src_rob = '0; disp_uses_nzcv = 1'b0; disp_nzcv_valid = 1'b0; disp_set_nzcv = 1'b0;
        disp_nzcv = '0; disp_nzcv_rob = '0; disp_dst_rob = '0;
    endtask

    task automatic clr_bcast();
        bc_valid = '0; bc_set_nzcv = '0; bc_rob = '0; bc_value = '0; bc_nzcv = '0;
    endtask

    task automatic disp(input alu_op_t op, input logic v0, input logic [DW-1:0] a,
                        input logic [RW-1:0] t0, input logic v1, input logic [DW-1:0] b,
                        input logic [RW-1:0] t1, input logic [RW-1:0] dst);
        clr_disp();
        disp_valid = 1'b1; disp_op = op;
        disp_src_valid = {v1, v0}; disp_src_value[0] = a; disp_src_value[1] = b;
        disp_src_rob[0] = t0; disp_src_rob[1] = t1; disp_dst_rob = dst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_rob = '0; head = '0; fu_ready = 1'b0;
        clr_disp(); clr_bcast();
        tick(); tick();
        chk("rst_disp_ready", 64'(disp_ready), 64'd0);
        chk("rst_issue_valid", 64'(iss_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1; #1;
        chk("post_rst_disp_ready", 64'(disp_ready), 64'd1);

        // 1: simple ADD, both operands ready
        fu_ready = 1'b1;
        disp(ALU_ADD, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd0); #1;
        chk("t1_no_issue_yet", 64'(iss_valid), 64'd0);
        tick(); clr_disp(); #1;
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_issue_valid", 64'(iss_valid), 64'd1);
        chk("t1_val_a", 64'(iss_a), 64'd5);
        chk("t1_val_b", 64'(iss_b), 64'd7);
        chk("t1_op", 64'(iss_op), 64'(ALU_ADD));
        tick();
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_idle", 64'(iss_valid), 64'd0);

        // 2: op1 waits on tag 3, woken by port 1
        disp(ALU_SUB, 1'b0, 32'd0, 4'd3, 1'b1, 32'd9, 4'd0, 4'd4);
        tick(); clr_disp(); #1;
        chk("t2_waiting", 64'(iss_valid), 64'd0);
        bc_valid[1] = 1'b1; bc_rob[1] = 4'd3; bc_value[1] = 32'd42; #1;
        chk("t2_not_same_cycle", 64'(iss_valid), 64'd0);
        tick(); clr_bcast(); #1;
        chk("t2_woken", 64'(iss_valid), 64'd1);
        chk("t2_val_a", 64'(iss_a), 64'd42);
        chk("t2_val_b", 64'(iss_b), 64'd9);
        tick();
        chk("t2_count0", 64'(count), 64'd0);

        // 3: fill, backpressure, free one, issue+dispatch same cycle
        fu_ready = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(ALU_ADD, 1'b1, 32'(i * 10), 4'd0, 1'b1, 32'(i), 4'd0, 4'(i)); #1;
            chk("t3_fill_ready", 64'(disp_ready), 64'd1);
            tick();
        end
        clr_disp(); #1;
        chk("t3_count8", 64'(count), 64'd8);
        chk("t3_full", 64'(disp_ready), 64'd0);
        chk("t3_issue_slot0", 64'(iss_a), 64'd0);
        tick();
        chk("t3_hold_count", 64'(count), 64'd8);
        chk("t3_hold_val", 64'(iss_a), 64'd0);
        fu_ready = 1'b1; tick(); fu_ready = 1'b0; #1;
        chk("t3_count7", 64'(count), 64'd7);
        chk("t3_ready_again", 64'(disp_ready), 64'd1);
        chk("t3_next_slot1", 64'(iss_a), 64'd10);
        fu_ready = 1'b1;
        disp(ALU_SUB, 1'b1, 32'd99, 4'd0, 1'b1, 32'd0, 4'd0, 4'd9);
        tick(); clr_disp(); fu_ready = 1'b0; #1;
        chk("t3_net_count", 64'(count), 64'd7);
`ifdef RS_OLDEST_FIRST_EN
        chk("t3_after_swap", 64'(iss_a), 64'd20);
`else
        chk("t3_after_swap", 64'(iss_a), 64'd99);
`endif
        fu_ready = 1'b1;
        repeat (7) tick();
        fu_ready = 1'b0; #1;
        chk("t3_drained", 64'(count), 64'd0);

        // 4: flush with wrapped ROB head
        head = 4'd14;
        disp(ALU_ADD, 1'b1, 32'd15, 4'd0, 1'b1, 32'd0, 4'd0, 4'd15); tick();
        disp(ALU_ADD, 1'b1, 32'd0,  4'd0, 1'b1, 32'd0, 4'd0, 4'd0);  tick();
        disp(ALU_ADD, 1'b1, 32'd1,  4'd0, 1'b1, 32'd0, 4'd0, 4'd1);  tick();
        disp(ALU_ADD, 1'b1, 32'd2,  4'd0, 1'b1, 32'd0, 4'd0, 4'd2);  tick();
        clr_disp(); #1;
        chk("t4_count4", 64'(count), 64'd4);
        chk("t4_ready_pre", 64'(iss_valid), 64'd1);
        flush = 1'b1; flush_rob = 4'd0; fu_ready = 1'b1;
        disp(ALU_ADD, 1'b1, 32'd3, 4'd0, 1'b1, 32'd0, 4'd0, 4'd3); #1;
        chk("t4_flush_no_issue", 64'(iss_valid), 64'd0);
        chk("t4_flush_no_disp", 64'(disp_ready), 64'd0);
        tick(); flush = 1'b0; fu_ready = 1'b0; clr_disp(); #1;
        chk("t4_survivors", 64'(count), 64'd2);
        chk("t4_oldest_dst", 64'(iss_dst), 64'd15);
        fu_ready = 1'b1; tick();
        chk("t4_second_dst", 64'(iss_dst), 64'd0);
        tick(); fu_ready = 1'b0; #1;
        chk("t4_empty", 64'(count), 64'd0);

        // 5: policy -- tag 2 in slot 0, tag 1 in slot 5, blockers in between
        head = 4'd0;
        disp(ALU_ADD, 1'b1, 32'd2, 4'd0, 1'b1, 32'd0, 4'd0, 4'd2); tick();
        for (int i = 0; i < 4; i++) begin
            disp(ALU_ADD, 1'b0, 32'd0, 4'd8, 1'b1, 32'd0, 4'd0, 4'(10 + i)); tick();
        end
        disp(ALU_ADD, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 4'd0, 4'd1); tick();
        clr_disp(); #1;
        chk("t5_count6", 64'(count), 64'd6);
`ifdef RS_OLDEST_FIRST_EN
        chk("t5_first_dst", 64'(iss_dst), 64'd1);
`else
        chk("t5_first_dst", 64'(iss_dst), 64'd2);
`endif
        bc_valid[0] = 1'b1; bc_rob[0] = 4'd8; bc_value[0] = 32'd5; fu_ready = 1'b1;
        tick(); clr_bcast(); #1;
        chk("t5_count5", 64'(count), 64'd5);
        repeat (5) tick();
        fu_ready = 1'b0; #1;
        chk("t5_empty", 64'(count), 64'd0);

        // 6: dispatch-cycle wakeup of op2 and NZCV
        fu_ready = 1'b1;
        disp(ALU_ADD, 1'b1, 32'd3, 4'd0, 1'b0, 32'd0, 4'd5, 4'd7);
        disp_uses_nzcv = 1'b1; disp_nzcv_rob = 4'd6;
        bc_valid = 2'b11;
        bc_rob[0] = 4'd5; bc_value[0] = 32'd77; bc_set_nzcv[0] = 1'b0;
        bc_rob[1] = 4'd6; bc_value[1] = 32'd123; bc_set_nzcv[1] = 1'b1; bc_nzcv[1] = 4'b1010;
        tick(); clr_disp(); clr_bcast(); #1;
        chk("t6_issue", 64'(iss_valid), 64'd1);
        chk("t6_val_b", 64'(iss_b), 64'd77);
        chk("t6_val_a", 64'(iss_a), 64'd3);
        chk("t6_nzcv", 64'(iss_nzcv), 64'hA);
        chk("t6_uses_nzcv", 64'(iss_uses_nzcv), 64'd1);
        tick();
        chk("t6_empty", 64'(count), 64'd0);

        // 7: duplicate tag on both ports; NZCV only from a set_nzcv port
        fu_ready = 1'b0;
        disp(ALU_AND, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'd8);
        disp_uses_nzcv = 1'b1; disp_nzcv_rob = 4'd7; disp_set_nzcv = 1'b1;
        tick(); clr_disp(); #1;
        chk("t7_waiting", 64'(iss_valid), 64'd0);
        bc_valid = 2'b11;
        bc_rob[0] = 4'd7; bc_value[0] = 32'd11; bc_set_nzcv[0] = 1'b0; bc_nzcv[0] = 4'b0001;
        bc_rob[1] = 4'd7; bc_value[1] = 32'd22; bc_set_nzcv[1] = 1'b1; bc_nzcv[1] = 4'b0010;
        tick(); clr_bcast(); #1;
        chk("t7_issue", 64'(iss_valid), 64'd1);
        chk("t7_lowest_port_val", 64'(iss_a), 64'd11);
        chk("t7_nzcv_from_set_port", 64'(iss_nzcv), 64'h2);
        chk("t7_set_nzcv", 64'(iss_set_nzcv), 64'd1);
        chk("t7_op", 64'(iss_op), 64'(ALU_AND));
        fu_ready = 1'b1; tick(); fu_ready = 1'b0; #1;
        chk("t7_empty", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
